// File: rtl/dsc_path_top.sv
// dsc_path_top: Dijkstra shortest-path engine over up to 2^ADDR_WIDTH nodes.
//
// A start strobe latches fonte/destino and runs a search driven by a small
// open set (NUM_NA active slots). Each selected node is marked established,
// its predecessor is written to the anterior memory, and its relation word
// is scanned one neighbour slot per cycle. When destino is established, the
// path is streamed back from destino to fonte. pronto_out then pulses once.
//
// Ports:
//   clk, rst_n                    clock (rising edge), async active-high reset
//   top_addr_fonte_in/_destino_in source/destination, sampled on top_wr_fonte_in
//   top_wr_fonte_in               one-cycle start strobe (accepted only in IDLE)
//   obstaculos_wr_*               obstacle memory write port (applied only in IDLE)
//   caminho_addr_out/_valid_out   path stream, destino first, fonte last
//   distancia_out                 destino distance, held until the next start
//   pronto_out                    one-cycle completion pulse
//   sem_caminho_out               pulses with pronto_out when destino is unreachable
//   ocupado_out                   high from start until pronto_out
//
// Handshake: the start strobe has no ready signal. It is accepted when the
// engine is in IDLE and dropped otherwise. ocupado_out=1 marks the window in
// which strobes are dropped.
module dsc_path_top #(
  parameter int MAX_VIZINHOS        = 8,
  parameter int ADDR_WIDTH          = 6,
  parameter int CUSTO_WIDTH         = 4,
  parameter int UMA_RELACAO_WIDTH   = ADDR_WIDTH + CUSTO_WIDTH,
  parameter int RELACOES_DATA_WIDTH = MAX_VIZINHOS * UMA_RELACAO_WIDTH,
  parameter int DISTANCIA_WIDTH     = 10,
  parameter int CRITERIO_WIDTH      = DISTANCIA_WIDTH + 1,
  parameter int NUM_NA              = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_WIDTH-1:0]      top_addr_fonte_in,
  input  logic [ADDR_WIDTH-1:0]      top_addr_destino_in,
  input  logic                       top_wr_fonte_in,
  input  logic                       obstaculos_wr_data_in,
  input  logic                       obstaculos_wr_enable_in,
  input  logic [ADDR_WIDTH-1:0]      obstaculos_wr_addr_in,
  output logic [ADDR_WIDTH-1:0]      caminho_addr_out,
  output logic                       caminho_valid_out,
  output logic [DISTANCIA_WIDTH-1:0] distancia_out,
  output logic                       pronto_out,
  output logic                       sem_caminho_out,
  output logic                       ocupado_out
);
  localparam int AW     = ADDR_WIDTH;
  localparam int CW     = CUSTO_WIDTH;
  localparam int DW     = DISTANCIA_WIDTH;
  localparam int URW    = UMA_RELACAO_WIDTH;
  localparam int NNODES = 1 << AW;
  localparam int NA_IW  = $clog2(NUM_NA);
  localparam int SL_IW  = $clog2(MAX_VIZINHOS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_SELECT = 3'd2;
  localparam logic [2:0] S_EXPAND = 3'd3;
  localparam logic [2:0] S_TRACE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // Relation memory is loaded by backdoor only; it has no write port.
  logic [RELACOES_DATA_WIDTH-1:0] mem_relacoes   [NNODES];
  logic                           mem_obstaculos [NNODES];
  logic [AW-1:0]                  mem_anterior   [NNODES];

  logic [2:0]   state;
  logic [AW-1:0] fonte, destino, cur_node, trace_node;
  logic [DW-1:0] cur_dist;
  logic [RELACOES_DATA_WIDTH-1:0] rel_word;
  logic [SL_IW-1:0] slot_idx;
  logic         no_path;
  logic [NNODES-1:0] est;

  // Open set
  logic [NUM_NA-1:0] na_valid;
  logic [AW-1:0]     na_node [NUM_NA];
  logic [DW-1:0]     na_dist [NUM_NA];
  logic [AW-1:0]     na_ant  [NUM_NA];

  // Selection: minimum zero-extended distance; strict '<' keeps the lowest
  // index on ties. Empty slots compare as all-ones, above any real distance.
  logic                      sel_found;
  logic [NA_IW-1:0]          sel_idx;
  logic [CRITERIO_WIDTH-1:0] sel_crit;
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_crit  = '1;
    for (int i = 0; i < NUM_NA; i++) begin
      if (na_valid[i] && ({1'b0, na_dist[i]} < sel_crit)) begin
        sel_found = 1'b1;
        sel_idx   = NA_IW'(i);
        sel_crit  = {1'b0, na_dist[i]};
      end
    end
  end

  // Expansion of the current neighbour slot
  logic [URW-1:0] slot;
  logic [AW-1:0]  nb;
  logic [CW-1:0]  custo;
  logic [DW:0]    sum;
  logic [DW-1:0]  nd;
  logic           skip, match_hit, free_hit;
  logic [NA_IW-1:0] match_idx, free_idx;
  always_comb begin
    slot      = rel_word[32'(slot_idx) * URW +: URW];
    nb        = slot[URW-1:CW];
    custo     = slot[CW-1:0];
    sum       = {1'b0, cur_dist} + {{(DW - CW + 1){1'b0}}, custo};
    nd        = sum[DW] ? '1 : sum[DW-1:0];
    skip      = (custo == '0) || mem_obstaculos[nb] || est[nb];
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int i = 0; i < NUM_NA; i++) begin
      if (!match_hit && na_valid[i] && (na_node[i] == nb)) begin
        match_hit = 1'b1;
        match_idx = NA_IW'(i);
      end
      if (!free_hit && !na_valid[i]) begin
        free_hit = 1'b1;
        free_idx = NA_IW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && obstaculos_wr_enable_in)
      mem_obstaculos[obstaculos_wr_addr_in] <= obstaculos_wr_data_in;
    if (state == S_SELECT && sel_found)
      mem_anterior[na_node[sel_idx]] <= na_ant[sel_idx];
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state             <= S_IDLE;
      caminho_addr_out  <= '0;
      caminho_valid_out <= 1'b0;
      distancia_out     <= '0;
      pronto_out        <= 1'b0;
      sem_caminho_out   <= 1'b0;
      ocupado_out       <= 1'b0;
      fonte             <= '0;
      destino           <= '0;
      cur_node          <= '0;
      cur_dist          <= '0;
      trace_node        <= '0;
      rel_word          <= '0;
      slot_idx          <= '0;
      no_path           <= 1'b0;
      est               <= '0;
      na_valid          <= '0;
      for (int i = 0; i < NUM_NA; i++) begin
        na_node[i] <= '0;
        na_dist[i] <= '0;
        na_ant[i]  <= '0;
      end
    end else begin
      caminho_valid_out <= 1'b0;
      pronto_out        <= 1'b0;
      sem_caminho_out   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (top_wr_fonte_in) begin
            fonte         <= top_addr_fonte_in;
            destino       <= top_addr_destino_in;
            distancia_out <= '0;
            ocupado_out   <= 1'b1;
            state         <= S_INIT;
          end
        end
        S_INIT: begin
          est         <= '0;
          na_valid    <= NUM_NA'(1);
          na_node[0]  <= fonte;
          na_dist[0]  <= '0;
          na_ant[0]   <= fonte;
          no_path     <= 1'b0;
          state       <= S_SELECT;
        end
        S_SELECT: begin
          if (!sel_found) begin
            no_path <= 1'b1;
            state   <= S_DONE;
          end else begin
            est[na_node[sel_idx]] <= 1'b1;
            na_valid[sel_idx]     <= 1'b0;
            cur_node              <= na_node[sel_idx];
            cur_dist              <= na_dist[sel_idx];
            if (na_node[sel_idx] == destino) begin
              distancia_out <= na_dist[sel_idx];
              trace_node    <= destino;
              state         <= S_TRACE;
            end else begin
              rel_word <= mem_relacoes[na_node[sel_idx]];
              slot_idx <= '0;
              state    <= S_EXPAND;
            end
          end
        end
        S_EXPAND: begin
          if (!skip) begin
            if (match_hit) begin
              if (nd < na_dist[match_idx]) begin
                na_dist[match_idx] <= nd;
                na_ant[match_idx]  <= cur_node;
              end
            end else if (free_hit) begin
              na_valid[free_idx] <= 1'b1;
              na_node[free_idx]  <= nb;
              na_dist[free_idx]  <= nd;
              na_ant[free_idx]   <= cur_node;
            end
          end
          if (slot_idx == SL_IW'(MAX_VIZINHOS - 1)) state <= S_SELECT;
          else slot_idx <= slot_idx + 1'b1;
        end
        S_TRACE: begin
          caminho_addr_out  <= trace_node;
          caminho_valid_out <= 1'b1;
          if (trace_node == fonte) state <= S_DONE;
          else trace_node <= mem_anterior[trace_node];
        end
        S_DONE: begin
          pronto_out      <= 1'b1;
          sem_caminho_out <= no_path;
          ocupado_out     <= 1'b0;
          state           <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dsc_path_top.sv
// tb_dsc_path_top: directed-vector bench for dsc_path_top. Graphs are loaded
// into the relation memory by backdoor, obstacles through the write port.
module tb_dsc_path_top;
  localparam int AW = 6;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] fonte_in = '0, destino_in = '0, obs_addr = '0;
  logic          start = 1'b0, obs_data = 1'b0, obs_en = 1'b0;
  logic [AW-1:0] caminho_addr;
  logic          caminho_valid, pronto, sem_caminho, ocupado;
  logic [DW-1:0] distancia;

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] got_q[$];

  dsc_path_top dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .top_addr_fonte_in       (fonte_in),
    .top_addr_destino_in     (destino_in),
    .top_wr_fonte_in         (start),
    .obstaculos_wr_data_in   (obs_data),
    .obstaculos_wr_enable_in (obs_en),
    .obstaculos_wr_addr_in   (obs_addr),
    .caminho_addr_out        (caminho_addr),
    .caminho_valid_out       (caminho_valid),
    .distancia_out           (distancia),
    .pronto_out              (pronto),
    .sem_caminho_out         (sem_caminho),
    .ocupado_out             (ocupado)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic clear_graph();
    for (int n = 0; n < 64; n++) dut.mem_relacoes[n] = '0;
  endtask

  task automatic add_half(input int a, input int b, input int c);
    logic [79:0] w;
    bit placed;
    w = dut.mem_relacoes[a];
    placed = 0;
    for (int k = 0; k < 8; k++)
      if (!placed && w[k*10 +: 4] == 4'd0) begin
        w[k*10 +: 10] = {6'(b), 4'(c)};
        placed = 1;
      end
    dut.mem_relacoes[a] = w;
  endtask

  task automatic add_edge(input int a, input int b, input int c);
    add_half(a, b, c);
    add_half(b, a, c);
  endtask

  task automatic write_obstacle(input int a, input logic v);
    @(posedge clk); #1;
    obs_addr = 6'(a); obs_data = v; obs_en = 1'b1;
    @(posedge clk); #1;
    obs_en = 1'b0;
  endtask

  task automatic clear_obstacles();
    for (int n = 0; n < 64; n++) write_obstacle(n, 1'b0);
  endtask

  task automatic pulse_start(input int f, input int d);
    @(posedge clk); #1;
    fonte_in = 6'(f); destino_in = 6'(d); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs one search and checks it against exp_q / exp_dist / exp_sem.
  // With poke set, a conflicting start strobe is issued while busy.
  task automatic run_search(input string tag, input int f, input int d,
                            input int exp_dist, input bit exp_sem, input bit poke);
    bit seen_pronto;
    logic got_sem;
    logic [DW-1:0] got_dist;
    got_q.delete();
    seen_pronto = 0;
    got_sem = 1'b0;
    got_dist = '0;
    pulse_start(f, d);
    @(negedge clk);
    check({tag, "_busy"}, 32'(ocupado), 32'd1);
    for (int cyc = 0; cyc < 3000 && !seen_pronto; cyc++) begin
      if (poke && cyc == 3) begin
        fonte_in = 6'd5; destino_in = 6'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (caminho_valid) got_q.push_back(caminho_addr);
      if (pronto) begin
        seen_pronto = 1;
        got_sem  = sem_caminho;
        got_dist = distancia;
        check({tag, "_idle_at_pronto"}, 32'(ocupado), 32'd0);
      end
      if (!seen_pronto) @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_pronto_seen"}, 32'(seen_pronto), 32'd1);
    check({tag, "_sem_caminho"}, 32'(got_sem), 32'(exp_sem));
    check({tag, "_distancia"}, 32'(got_dist), 32'(exp_dist));
    check({tag, "_path_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_path_node"}, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    int stray;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(caminho_valid), 32'd0);
    check("rst_addr", 32'(caminho_addr), 32'd0);
    check("rst_dist", 32'(distancia), 32'd0);
    check("rst_pronto", 32'(pronto), 32'd0);
    check("rst_sem", 32'(sem_caminho), 32'd0);
    check("rst_busy", 32'(ocupado), 32'd0);
    rst_n = 1'b0;
    clear_obstacles();

    // Chain 0-1(3), 1-2(2), 2-3(4)
    clear_graph();
    add_edge(0, 1, 3); add_edge(1, 2, 2); add_edge(2, 3, 4);
    exp_q = '{6'd3, 6'd2, 6'd1, 6'd0};
    run_search("chain", 0, 3, 9, 1'b0, 1'b0);

    // Diamond 0-1(1), 1-3(1), 0-2(1), 2-3(5)
    clear_graph();
    add_edge(0, 1, 1); add_edge(1, 3, 1); add_edge(0, 2, 1); add_edge(2, 3, 5);
    exp_q = '{6'd3, 6'd1, 6'd0};
    run_search("diamond", 0, 3, 2, 1'b0, 1'b0);

    // Same diamond with node 1 blocked
    write_obstacle(1, 1'b1);
    exp_q = '{6'd3, 6'd2, 6'd0};
    run_search("diamond_obst", 0, 3, 6, 1'b0, 1'b0);
    write_obstacle(1, 1'b0);

    // fonte == destino
    exp_q = '{6'd5};
    run_search("self", 5, 5, 0, 1'b0, 1'b0);

    // Disconnected destino
    clear_graph();
    add_edge(0, 1, 2);
    exp_q.delete();
    run_search("disconnected", 0, 3, 0, 1'b1, 1'b0);

    // Async reset in the middle of a chain search
    clear_graph();
    add_edge(0, 1, 3); add_edge(1, 2, 2); add_edge(2, 3, 4);
    pulse_start(0, 3);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("midrst_busy", 32'(ocupado), 32'd0);
    check("midrst_state", 32'(dut.state), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (pronto || caminho_valid) stray++;
    end
    check("midrst_no_pronto", 32'(stray), 32'd0);

    // Restart after the abort, with a start strobe issued while busy
    exp_q = '{6'd3, 6'd2, 6'd1, 6'd0};
    run_search("restart", 0, 3, 9, 1'b0, 1'b1);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
